// File: rtl/counter_cmd_arbiter_if.sv
// Bundle between the requesters/counter and counter_cmd_arbiter.
//
// Handshake: a requester raises req[i] together with cmd[i]/arg[i] and holds all
// three until it sees gnt[i]. gnt[i] is a one-cycle pulse, and cmd/arg have
// already been captured when it appears. The requester may drop req in the
// cycle after gnt. Completion comes later as a one-cycle done[i] pulse, with
// sat valid in that same cycle.
//
// Signals
//   req   [N_REQ]        request per requester
//   cmd   [2*N_REQ]      per requester: 00 NOP, 01 LOAD, 10 UP, 11 DOWN
//   arg   [WIDTH*N_REQ]  LOAD value or step count per requester
//   gnt   [N_REQ]        grant pulse
//   done  [N_REQ]        completion pulse to the owner
//   sat   1              command stopped early on High/Low (valid with done)
//   busy  1              arbiter not idle
//   cnt_load/cnt_in/cnt_up/cnt_down   controls to the shared counter
//   cnt_high/cnt_low                  status decodes from the shared counter
//
// Modports
//   slave  : the arbiter
//   master : the environment (requesters plus the counter itself)
interface counter_cmd_arbiter_if #(
  parameter int WIDTH = 5,
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     cmd;
  logic [WIDTH*N_REQ-1:0] arg;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   sat;
  logic                   busy;
  logic                   cnt_load;
  logic [WIDTH-1:0]       cnt_in;
  logic                   cnt_up;
  logic                   cnt_down;
  logic                   cnt_high;
  logic                   cnt_low;

  modport slave (
    input  req, cmd, arg, cnt_high, cnt_low,
    output gnt, done, sat, busy, cnt_load, cnt_in, cnt_up, cnt_down
  );

  modport master (
    output req, cmd, arg, cnt_high, cnt_low,
    input  gnt, done, sat, busy, cnt_load, cnt_in, cnt_up, cnt_down
  );
endinterface

// File: rtl/counter_cmd_arbiter.sv
// Round-robin arbiter and sequencer that shares one registered Up/Down counter
// between N_REQ requesters. Each granted command (NOP, LOAD, UP n, DOWN n) is
// turned into counter control pulses, one per cycle. Completion, and early
// saturation at High/Low, are reported back to the owner.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        counter_cmd_arbiter_if.slave (requests, grants, counter controls)
//   dbg_state  current FSM state (0 IDLE, 1 EXEC, 2 DONE)
module counter_cmd_arbiter #(
  parameter int WIDTH = 5,
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  counter_cmd_arbiter_if.slave   bus,
  output logic [1:0]             dbg_state
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_UP   = 2'b10;
  localparam logic [1:0] CMD_DOWN = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sat_q, sat_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             found;
  logic [OW-1:0]    pick;
  logic [OW:0]      cand_sum;
  logic [OW-1:0]    cand;
  logic [1:0]       cmd_sel;
  logic [WIDTH-1:0] arg_sel;

  logic             load_c;
  logic [WIDTH-1:0] in_c;
  logic             up_c;
  logic             down_c;
  logic             saturated;
  logic             step_dir_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= OW'(N_REQ - 1);
      cmd_q   <= CMD_NOP;
      arg_q   <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cmd_d    = cmd_q;
    arg_d    = arg_q;
    rem_d    = rem_q;
    sat_d    = sat_q;
    gnt_d    = '0;
    load_c   = 1'b0;
    in_c     = '0;
    up_c     = 1'b0;
    down_c   = 1'b0;
    found    = 1'b0;
    pick     = '0;
    cand_sum = '0;
    cand     = '0;
    cmd_sel  = CMD_NOP;
    arg_sel  = '0;

    // Rotating search starting just after the last owner. ptr < N_REQ and
    // k <= N_REQ, so a single subtraction wraps the candidate index.
    for (int k = 1; k <= N_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (OW+1)'(k);
      if (cand_sum >= (OW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (OW+1)'(N_REQ);
      end
      cand = cand_sum[OW-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (pick == OW'(i)) begin
        cmd_sel = bus.cmd[2*i +: 2];
        arg_sel = bus.arg[WIDTH*i +: WIDTH];
      end
    end

    // UP stops at High and DOWN stops at Low. The check comes before each
    // pulse, so the counter never wraps.
    step_dir_up = (cmd_q == CMD_UP);
    saturated   = step_dir_up ? bus.cnt_high : bus.cnt_low;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = pick;
          cmd_d   = cmd_sel;
          arg_d   = arg_sel;
          rem_d   = arg_sel;
          sat_d   = 1'b0;
          for (int i = 0; i < N_REQ; i++) begin
            gnt_d[i] = (pick == OW'(i));
          end
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cmd_q == CMD_NOP) begin
          state_d = S_DONE;
        end else if (cmd_q == CMD_LOAD) begin
          load_c  = 1'b1;
          in_c    = arg_q;
          state_d = S_DONE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else if (saturated) begin
          sat_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          up_c   = step_dir_up;
          down_c = !step_dir_up;
          rem_d  = rem_q - 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bus.done[i] = (state_q == S_DONE) && (owner_q == OW'(i));
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sat      = (state_q == S_DONE) && sat_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.cnt_load = load_c;
  assign bus.cnt_in   = in_c;
  assign bus.cnt_up   = up_c;
  assign bus.cnt_down = down_c;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Bench for counter_cmd_arbiter with a behavioural model of the shared counter.
// Expected grant order, pulse counts, saturation and latency are derived from
// the command rules: pulses = min(n, headroom), sat = n > headroom, and
// done arrives pulses+2 cycles after the request-sample edge.
module tb_counter_cmd_arbiter;
  localparam int WIDTH = 5;
  localparam int N_REQ = 2;
  localparam int MAXV  = (1 << WIDTH) - 1;

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_LOAD = 2'b01;
  localparam logic [1:0] C_UP   = 2'b10;
  localparam logic [1:0] C_DOWN = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       dbg_state;
  logic [WIDTH-1:0] counter = '0;

  int checks = 0;
  int errors = 0;

  int               model_cnt = 0;
  int               model_ptr = N_REQ - 1;
  logic [N_REQ-1:0] pend = '0;
  logic [1:0]       p_cmd [N_REQ];
  int               p_arg [N_REQ];

  counter_cmd_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  counter_cmd_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / counter environment ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cnt_load)      counter <= bus.cnt_in;
    else if (bus.cnt_up)   counter <= counter + 1'b1;
    else if (bus.cnt_down) counter <= counter - 1'b1;
  end

  assign bus.cnt_high = (counter == WIDTH'(MAXV));
  assign bus.cnt_low  = (counter == '0);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {16'd0, dbg_state, bus.gnt, bus.done, bus.sat, bus.busy, bus.cnt_load,
            bus.cnt_in, bus.cnt_up, bus.cnt_down};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic post(input int i, input logic [1:0] c, input int a);
    bus.req[i]               = 1'b1;
    bus.cmd[2*i +: 2]        = c;
    bus.arg[WIDTH*i +: WIDTH] = WIDTH'(a);
    pend[i]  = 1'b1;
    p_cmd[i] = c;
    p_arg[i] = a;
  endtask

  // mode 0: owner drops req at gnt; 1: keep req; 2: keep, then release all at done
  task automatic serve(input int mode);
    int exp_idx, w, k, a, head, p, exp_sat, new_cnt;
    int n_up, n_down, n_load, load_val, extra_gnt;
    logic [1:0] c;
    exp_idx = -1;
    for (int j = 1; j <= N_REQ; j++) begin
      int cidx;
      cidx = (model_ptr + j) % N_REQ;
      if (exp_idx < 0 && pend[cidx]) exp_idx = cidx;
    end
    if (exp_idx < 0) begin
      check("no_pending_request", 0, 1);
      return;
    end
    w = 0;
    while (w < 10) begin
      @(negedge clk);
      w++;
      if (bus.gnt != '0) break;
    end
    check("gnt_seen", 32'(bus.gnt != '0), 1);
    if (bus.gnt == '0) return;
    check("gnt_latency", w, 1);
    check("gnt_owner", 32'(bus.gnt), 32'(1 << exp_idx));

    c = p_cmd[exp_idx];
    a = p_arg[exp_idx];
    p = 0; exp_sat = 0; new_cnt = model_cnt;
    case (c)
      C_LOAD: new_cnt = a;
      C_UP: begin
        head = MAXV - model_cnt;
        p = (a < head) ? a : head;
        exp_sat = (a > head) ? 1 : 0;
        new_cnt = model_cnt + p;
      end
      C_DOWN: begin
        head = model_cnt;
        p = (a < head) ? a : head;
        exp_sat = (a > head) ? 1 : 0;
        new_cnt = model_cnt - p;
      end
      default: ;
    endcase

    if (mode == 0) begin
      bus.req[exp_idx] = 1'b0;
      pend[exp_idx] = 1'b0;
    end

    n_up = 0; n_down = 0; n_load = 0; load_val = 0; extra_gnt = 0;
    for (k = 1; k <= 45; k++) begin
      if (k > 1) begin
        @(negedge clk);
        if (bus.gnt != '0) extra_gnt++;
      end
      if (bus.cnt_up)   n_up++;
      if (bus.cnt_down) n_down++;
      if (bus.cnt_load) begin
        n_load++;
        load_val = int'(bus.cnt_in);
      end
      if (bus.done != '0) break;
    end

    check("done_owner", 32'(bus.done), 32'(1 << exp_idx));
    check("done_latency", k, p + 2);
    check("sat", 32'(bus.sat), exp_sat);
    check("busy_at_done", 32'(bus.busy), 1);
    check("up_pulses", n_up, (c == C_UP) ? p : 0);
    check("down_pulses", n_down, (c == C_DOWN) ? p : 0);
    check("load_pulses", n_load, (c == C_LOAD) ? 1 : 0);
    if (c == C_LOAD) check("load_value", load_val, a);
    check("single_gnt", extra_gnt, 0);
    check("counter_value", 32'(counter), new_cnt);

    model_ptr = exp_idx;
    model_cnt = new_cnt;

    if (mode == 2) begin
      bus.req = '0;
      pend = '0;
    end
    // No arbitration in DONE: the cycle after done must be grant-free.
    @(negedge clk);
    check("idle_gap_no_gnt", 32'(bus.gnt), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mask;
    bus.req = '0;
    bus.cmd = '0;
    bus.arg = '0;

    // Reset held with active UP requests: everything stays quiet.
    rst_n   = 1'b0;
    bus.req = 2'b11;
    bus.cmd = {C_UP, C_UP};
    bus.arg = {5'd3, 5'd3};
    repeat (4) begin
      @(negedge clk);
      check("reset_outputs", all_outs(), 0);
    end
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", all_outs(), 0);

    // LOAD 5 from requester 0.
    post(0, C_LOAD, 5);
    serve(0);
    // UP 3 from requester 1 (5 -> 8), then DOWN 0.
    post(1, C_UP, 3);
    serve(0);
    post(1, C_DOWN, 0);
    serve(0);
    // Saturation both ways.
    post(0, C_LOAD, 29);
    serve(0);
    post(0, C_UP, 5);
    serve(0);
    post(1, C_LOAD, 1);
    serve(0);
    post(1, C_DOWN, 4);
    serve(0);
    // NOP.
    post(0, C_NOP, 17);
    serve(0);

    // Both requesters held from reset: strict alternation 0,1,0,1.
    rst_n = 1'b0;
    post(0, C_NOP, 0);
    post(1, C_NOP, 0);
    model_ptr = N_REQ - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    serve(1);
    serve(1);
    serve(1);
    serve(2);

    // Random commands, random subsets of simultaneous requesters.
    for (int it = 0; it < 24; it++) begin
      mask = $urandom_range(1, 3);
      for (int i = 0; i < N_REQ; i++) begin
        if (mask[i]) post(i, 2'($urandom_range(0, 3)), $urandom_range(0, MAXV));
      end
      while (pend != '0) serve(0);
    end

    // Reset in the middle of UP 10 from 10: abandoned after 3 pulses.
    post(1, C_LOAD, 10);
    serve(0);
    post(0, C_UP, 10);
    begin
      int w;
      w = 0;
      while (w < 10) begin
        @(negedge clk);
        w++;
        if (bus.gnt != '0) break;
      end
      check("abort_gnt_seen", 32'(bus.gnt), 1);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    bus.req = '0;
    pend    = '0;
    #1;
    check("abort_outputs_zero", all_outs(), 0);
    check("abort_counter", 32'(counter), model_cnt + 3);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done_in_reset", all_outs(), 0);
    end
    rst_n = 1'b1;
    model_cnt = model_cnt + 3;
    model_ptr = N_REQ - 1;
    repeat (4) begin
      @(negedge clk);
      check("abort_idle_after_release", all_outs(), 0);
      check("abort_counter_kept", 32'(counter), model_cnt);
    end

    // Still functional after the abort: DOWN 20 from 13 saturates.
    post(0, C_DOWN, 20);
    serve(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout observed=1 expected=0");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
